// File: rtl/cpu_types_pkg.sv
// Shared types for the execute stage: ALU opcodes, multiply/divide FSM states
// and the quotient value reported for a divide by zero.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL   = 4'b0000,
    ALU_SRL   = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0011,
    ALU_AND   = 4'b0100,
    ALU_OR    = 4'b0101,
    ALU_XOR   = 4'b0110,
    ALU_NOR   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_MULT  = 4'b1010,
    ALU_MULTU = 4'b1011,
    ALU_DIV   = 4'b1100,
    ALU_DIVU  = 4'b1101,
    ALU_MFHI  = 4'b1110,
    ALU_MFLO  = 4'b1111
  } aluop_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } md_state_t;

  localparam logic [63:0] MD_DIVZERO_Q = '1;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide on
// operand magnitudes, sign fix-up on the final edge, and the HI/LO registers.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   MD_IDLE | waiting for start with an MD opcode
//   MD_MUL  | one shift-add step per cycle, cnt_q counts down from WIDTH
//   MD_DIV  | one restoring-divide step per cycle, cnt_q counts down
//   MD_DONE | HI/LO just written, done pulse; a new start is accepted here
module md_unit
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  md_state_t          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               divz_q, divz_d;

  logic               is_signed, is_div, launch;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  always_comb begin
    is_signed = (op == ALU_MULT) || (op == ALU_DIV);
    is_div    = (op == ALU_DIV) || (op == ALU_DIVU);
    mag_a     = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b     = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    launch    = start && !flush && is_md_op(op) &&
                ((state_q == MD_IDLE) || (state_q == MD_DONE));
  end

  // Multiply keeps {partial product, remaining multiplier}; divide keeps
  // {remainder, dividend bits shifting into quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (state_q == MD_MUL)
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else
      acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod_fix = neg_res_q ? -acc_step : acc_step;
    q_fix    = neg_res_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    r_fix    = neg_rem_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    case (state_q)
      MD_IDLE, MD_DONE: begin
        if (launch) begin
          state_d   = is_div ? MD_DIV : MD_MUL;
          cnt_d     = CNT_INIT;
          acc_d     = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          opb_d     = is_div ? mag_b : mag_a;
          a_raw_d   = op_a;
          neg_res_d = is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          neg_rem_d = is_signed && op_a[WIDTH-1];
          divz_d    = is_div && (op_b == '0);
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_MUL, MD_DIV: begin
        if (flush) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = MD_DONE;
            if (state_q == MD_MUL) begin
              {hi_d, lo_d} = prod_fix;
            end else if (divz_q) begin
              lo_d = MD_DIVZERO_Q[WIDTH-1:0];
              hi_d = a_raw_q;
            end else begin
              lo_d = q_fix;
              hi_d = r_fix;
            end
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
    end
  end

  assign busy = (state_q == MD_MUL) || (state_q == MD_DIV);
  assign done = (state_q == MD_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU: combinational single-cycle datapath and flags, MFHI/MFLO
// mux, and the iterative multiply/divide unit that owns HI/LO.
module alu_md
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [3:0]       aluOP,
  input  logic [WIDTH-1:0] pA,
  input  logic [WIDTH-1:0] pB,
  input  logic             start,
  input  logic             flush,
  output logic [WIDTH-1:0] out,
  output logic             neg_flag,
  output logic             overflow_flag,
  output logic             zero_flag,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int M = WIDTH - 1;

  aluop_t           op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, dif;

  assign op    = aluop_t'(aluOP);
  assign shamt = pB[SHW-1:0];
  assign sum   = pA + pB;
  assign dif   = pA - pB;

  // MD opcodes fall to the default and drive zero; they only write HI/LO.
  always_comb begin
    out           = '0;
    neg_flag      = 1'b0;
    overflow_flag = 1'b0;
    case (op)
      ALU_SLL:  out = pA << shamt;
      ALU_SRL:  out = pA >> shamt;
      ALU_ADD: begin
        out           = sum;
        neg_flag      = sum[M];
        overflow_flag = (pA[M] == pB[M]) && (sum[M] != pA[M]);
      end
      ALU_SUB: begin
        out           = dif;
        neg_flag      = dif[M];
        overflow_flag = (pA[M] != pB[M]) && (dif[M] != pA[M]);
      end
      ALU_AND:  out = pA & pB;
      ALU_OR:   out = pA | pB;
      ALU_XOR:  out = pA ^ pB;
      ALU_NOR:  out = ~(pA | pB);
      ALU_SLT:  out = {{(WIDTH-1){1'b0}}, ($signed(pA) < $signed(pB))};
      ALU_SLTU: out = {{(WIDTH-1){1'b0}}, (pA < pB)};
      ALU_MFHI: out = hi;
      ALU_MFLO: out = lo;
      default:  out = '0;
    endcase
  end

  assign zero_flag = (out == '0);

  md_unit #(.WIDTH(WIDTH)) u_md (
    .clk   (CLK),
    .rst_n (nRST),
    .op    (aluOP),
    .start (start),
    .flush (flush),
    .op_a  (pA),
    .op_b  (pB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: 32-bit and 16-bit builds, MD results checked
// against a queue of expectations from an independent arithmetic model.
module tb_alu_md;
  import cpu_types_pkg::*;

  logic        clk = 1'b0;
  logic        nRST;
  always #5 clk = ~clk;

  logic [3:0]  aluOP;
  logic [31:0] pA, pB, out, hi, lo;
  logic        start, flush, neg_flag, overflow_flag, zero_flag, busy, done;

  logic [3:0]  aluOP16;
  logic [15:0] pA16, pB16, out16, hi16, lo16;
  logic        start16, flush16, neg16, ovf16, zero16, busy16, done16;

  alu_md #(.WIDTH(32)) dut (
    .CLK(clk), .nRST(nRST), .aluOP(aluOP), .pA(pA), .pB(pB), .start(start),
    .flush(flush), .out(out), .neg_flag(neg_flag), .overflow_flag(overflow_flag),
    .zero_flag(zero_flag), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  alu_md #(.WIDTH(16)) dut16 (
    .CLK(clk), .nRST(nRST), .aluOP(aluOP16), .pA(pA16), .pB(pB16), .start(start16),
    .flush(flush16), .out(out16), .neg_flag(neg16), .overflow_flag(ovf16),
    .zero_flag(zero16), .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
  );

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_hi, last_lo;

  // Reference {hi, lo} for a w-bit MD op, built from native 64-bit arithmetic.
  function automatic logic [63:0] md_model(input int w, input logic [3:0] op,
                                           input logic [31:0] a_in, input logic [31:0] b_in);
    logic [63:0] mask, ua, ub, up, h, l;
    longint      sa, sb, sp;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a_in} & mask;
    ub   = {32'd0, b_in} & mask;
    sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    h    = '0;
    l    = '0;
    case (op)
      ALU_MULT:  begin sp = sa * sb; h = sp >>> w; l = sp; end
      ALU_MULTU: begin up = ua * ub; h = up >> w;  l = up; end
      ALU_DIV: begin
        if (ub == 0) begin l = mask; h = ua; end
        else begin l = sa / sb; h = sa % sb; end
      end
      ALU_DIVU: begin
        if (ub == 0) begin l = mask; h = ua; end
        else begin l = ua / ub; h = ua % ub; end
      end
      default: ;
    endcase
    h = h & mask;
    l = l & mask;
    return {h[31:0], l[31:0]};
  endfunction

  task automatic launch(input bit use16, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(md_model(use16 ? 16 : 32, op, a, b));
    if (use16) begin
      aluOP16 = op; pA16 = a[15:0]; pB16 = b[15:0]; start16 = 1'b1;
    end else begin
      aluOP = op; pA = a; pB = b; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; start16 = 1'b0;
    pA = $urandom; pB = $urandom;
    pA16 = 16'($urandom); pB16 = 16'($urandom);
  endtask

  // Entered at the negedge after the launch edge; ends at the done cycle,
  // or one cycle later when chk_fall is set.
  task automatic wait_md(input bit use16, input string name, input int exp_busy,
                         input bit chk_fall);
    int          n = 0;
    int          guard = 0;
    logic [63:0] e;
    logic [31:0] h, l;
    while (!(use16 ? done16 : done) && guard < 300) begin
      if (use16 ? busy16 : busy) n++;
      guard++;
      @(negedge clk);
    end
    checks++;
    if (guard >= 300) begin
      errors++;
      $display("FAIL %s timeout: done not seen within 300 cycles", name);
    end
    checks++;
    if (n != exp_busy) begin
      errors++;
      $display("FAIL %s busy_window: got %0d cycles, want %0d", name, n, exp_busy);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    h = use16 ? {16'd0, hi16} : hi;
    l = use16 ? {16'd0, lo16} : lo;
    checks++;
    if (h !== e[63:32]) begin
      errors++;
      $display("FAIL %s hi: got %h, want %h", name, h, e[63:32]);
    end
    checks++;
    if (l !== e[31:0]) begin
      errors++;
      $display("FAIL %s lo: got %h, want %h", name, l, e[31:0]);
    end
    if (!use16) begin last_hi = e[63:32]; last_lo = e[31:0]; end
    if (chk_fall) begin
      @(negedge clk);
      checks++;
      if ((use16 ? done16 : done) !== 1'b0 || (use16 ? busy16 : busy) !== 1'b0) begin
        errors++;
        $display("FAIL %s done_pulse: done=%b busy=%b one cycle later, want 0 0", name,
                 use16 ? done16 : done, use16 ? busy16 : busy);
      end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    aluOP = ALU_ADD; pA = '0; pB = '0; start = 1'b0; flush = 1'b0;
    aluOP16 = ALU_ADD; pA16 = '0; pB16 = '0; start16 = 1'b0; flush16 = 1'b0;
    #12;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
    end
    @(negedge clk);
    nRST = 1'b1;
    last_hi = '0; last_lo = '0;
  endtask

  task automatic test_alu();
    logic [3:0]  t_op[12]  = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLTU,
                               ALU_NOR, ALU_AND, ALU_XOR, ALU_ADD, ALU_OR, ALU_SUB};
    logic [31:0] t_a[12]   = '{32'h7FFFFFFF, 32'h80000000, 32'h1, 32'h80000000, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'h0, 32'hF0F0F0F0, 32'h12345678, 32'hFFFFFFFF,
                               32'h00FF0000, 32'h5};
    logic [31:0] t_b[12]   = '{32'h1, 32'h1, 32'h21, 32'h4, 32'h1, 32'h1, 32'h0, 32'h0FF00FF0,
                               32'h12345678, 32'h1, 32'h000000FF, 32'h7};
    logic [31:0] t_out[12] = '{32'h80000000, 32'h7FFFFFFF, 32'h2, 32'h08000000, 32'h1, 32'h0,
                               32'hFFFFFFFF, 32'h00F000F0, 32'h0, 32'h0, 32'h00FF00FF,
                               32'hFFFFFFFE};
    logic        t_ov[12]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0};
    logic        t_ng[12]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      aluOP = t_op[i]; pA = t_a[i]; pB = t_b[i];
      #1;
      checks++;
      if (out !== t_out[i] || overflow_flag !== t_ov[i] || neg_flag !== t_ng[i] ||
          zero_flag !== (t_out[i] == 32'd0)) begin
        errors++;
        $display("FAIL alu_case%0d: out=%h ov=%b neg=%b zero=%b, want out=%h ov=%b neg=%b zero=%b",
                 i, out, overflow_flag, neg_flag, zero_flag, t_out[i], t_ov[i], t_ng[i],
                 (t_out[i] == 32'd0));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mult();
    launch(0, ALU_MULT, 32'hFFFFFFFD, 32'd7);
    checks++;
    if (out !== 32'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL md_out_zero: out=%h busy=%b, want out=0 busy=1", out, busy);
    end
    wait_md(0, "mult_neg3x7", 32, 1);
    launch(0, ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_md(0, "multu_max", 32, 1);
  endtask

  task automatic test_div();
    launch(0, ALU_DIV, 32'hFFFFFFF9, 32'd2);
    wait_md(0, "div_neg7by2", 32, 1);
    launch(0, ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_md(0, "div_minbyneg1", 32, 1);
    launch(0, ALU_DIVU, 32'd5, 32'd0);
    wait_md(0, "divu_by0", 32, 1);
  endtask

  task automatic test_mfhi_mflo();
    aluOP = ALU_MFHI;
    #1;
    checks++;
    if (out !== last_hi || zero_flag !== (last_hi == 32'd0)) begin
      errors++;
      $display("FAIL mfhi: out=%h zero=%b, want %h", out, zero_flag, last_hi);
    end
    aluOP = ALU_MFLO;
    #1;
    checks++;
    if (out !== last_lo || zero_flag !== (last_lo == 32'd0)) begin
      errors++;
      $display("FAIL mflo: out=%h zero=%b, want %h", out, zero_flag, last_lo);
    end
    @(negedge clk);
    launch(0, ALU_DIVU, 32'd0, 32'd3);
    wait_md(0, "divu_0by3", 32, 1);
    aluOP = ALU_MFLO;
    #1;
    checks++;
    if (out !== 32'd0 || zero_flag !== 1'b1) begin
      errors++;
      $display("FAIL mflo_zero: out=%h zero=%b, want 0 and 1", out, zero_flag);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    launch(0, ALU_MULT, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    aluOP = ALU_DIV; pA = 32'd100; pB = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_md(0, "start_while_busy", 32 - 6, 1);
  endtask

  task automatic test_back_to_back();
    launch(0, ALU_MULTU, 32'h12345678, 32'h9ABCDEF0);
    wait_md(0, "b2b_first", 32, 0);
    launch(0, ALU_DIV, 32'hFFFFFF9C, 32'd7);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_gap: busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    wait_md(0, "b2b_second", 32, 1);
  endtask

  task automatic test_flush();
    int seen_done = 0;
    launch(0, ALU_DIV, 32'd1000, 32'd9);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: busy=%b, want 0", busy);
    end
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) seen_done++;
      @(negedge clk);
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL flush_no_done: done seen %0d cycles, want 0", seen_done);
    end
    checks++;
    if (hi !== last_hi || lo !== last_lo) begin
      errors++;
      $display("FAIL flush_hilo: hi=%h lo=%h, want %h %h", hi, lo, last_hi, last_lo);
    end
    void'(exp_q.pop_back());
  endtask

  task automatic test_reset_mid();
    launch(0, ALU_MULT, 32'hFFFFFFFD, 32'd7);
    repeat (5) @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
    end
    @(negedge clk);
    nRST = 1'b1;
    void'(exp_q.pop_back());
    last_hi = '0; last_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_width16();
    launch(1, ALU_MULT, 32'hFFFD, 32'd7);
    wait_md(1, "w16_mult", 16, 1);
    launch(1, ALU_MULTU, 32'hFFFF, 32'hFFFF);
    wait_md(1, "w16_multu", 16, 1);
    launch(1, ALU_DIV, 32'hFFF9, 32'd2);
    wait_md(1, "w16_div", 16, 1);
    launch(1, ALU_DIV, 32'h8000, 32'hFFFF);
    wait_md(1, "w16_div_min", 16, 1);
    launch(1, ALU_DIVU, 32'd5, 32'd0);
    wait_md(1, "w16_divu0", 16, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_mfhi_mflo();
    test_ignore_start();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_width16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
